smult_accum: RTL and testbench

- Downstream consumer of the sync_smult signed multiplier in the pico-MIPS datapath.
- Sums the products of a fixed-length run of operand pairs; the 2N-bit products are summed into a wide signed accumulator.
- Produces the full sum, a saturated N-bit result after an optional arithmetic right shift, a sticky overflow flag and a one-cycle done pulse.
- Tracks the multiplier's one-cycle latency internally, so the controller only signals when operands are issued.

---
 rtl/smult_pkg.sv | 35 +++
 rtl/smult_accum_sat_shift.sv | 23 ++
 rtl/smult_accum.sv | 146 ++++++++++++++
 tb/tb_smult_accum.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smult_pkg.sv
// Shared types, default sizes and the saturation helper for the
// smult_accum datapath.
package smult_pkg;

    localparam int N_DEF     = 8;
    localparam int ACC_W_DEF = 20;
    localparam int LEN_W_DEF = 8;

    // Working width for shift/clamp; wide enough for any practical ACC_W.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a sign-extended value to the signed range of an n-bit integer.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] s,
        input int                      n
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/smult_accum_sat_shift.sv
// Combinational arithmetic right shift followed by a clamp to N signed bits.
module sat_shift
    import smult_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [N-1:0]     sat_out
);

    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] shifted;

    // Sign-extend to the working width so the clamp sees the true value.
    always_comb begin
        acc_ext = SAT_W'(acc_in);
        shifted = acc_ext >>> SHIFT;
        sat_out = N'(saturate(shifted, N));
    end

endmodule

// File: rtl/smult_accum.sv
// Accumulates a fixed-length run of sync_smult products into a wide signed
// sum, with sticky overflow, a saturated N-bit view and a done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last run's results
// RUN   | accepting operand issues, summing products one cycle later
// DONE  | one-cycle done pulse, results valid, then back to IDLE
module smult_accum
    import smult_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    op_valid,
    input  logic signed [2*N-1:0]   product,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [N-1:0]     result_sat,
    output logic                    overflow
);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        target_q, target_d;
    logic [LEN_W-1:0]        issued_q, issued_d;
    logic [LEN_W-1:0]        received_q, received_d;
    logic                    acc_en_q, acc_en_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [N-1:0]     res_q, res_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [N-1:0]     sum_sat;
    logic                    accept;

    // Sign-extended product and the candidate new sum.
    always_comb begin
        prod_ext = ACC_W'(product);
        acc_sum  = acc_q + prod_ext;
    end

    // Clamped view of the candidate sum, registered only on the final product.
    sat_shift #(
        .N     (N),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .acc_in  (acc_sum),
        .sat_out (sum_sat)
    );

    // Next-state, counter and accumulator updates.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        issued_d   = issued_q;
        received_d = received_q;
        acc_d      = acc_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    res_d      = '0;
                    ovf_d      = 1'b0;
                    issued_d   = '0;
                    received_d = '0;
                    target_d   = len;
                    state_d    = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Issues beyond the run length never reach the accumulator.
                accept = op_valid && (issued_q < target_q);
                if (accept) begin
                    issued_d = issued_q + 1'b1;
                end
                // The product for an accepted issue arrives one cycle later.
                if (acc_en_q) begin
                    acc_d      = acc_sum;
                    received_d = received_q + 1'b1;
                    if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                        (acc_sum[ACC_W-1] != acc_q[ACC_W-1])) begin
                        ovf_d = 1'b1;
                    end
                    if (received_d == target_q) begin
                        res_d   = sum_sat;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        acc_en_d = accept;
    end

    // State and datapath registers; reset abandons any run in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            issued_q   <= '0;
            received_q <= '0;
            acc_en_q   <= 1'b0;
            acc_q      <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            acc_en_q   <= acc_en_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
        end
    end

    // Status and result outputs.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        acc        = acc_q;
        result_sat = res_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_smult_accum.sv
// Bench for smult_accum fed by a behavioural sync_smult; two DUTs share the
// stimulus, one with SHIFT=0 and one with SHIFT=7.
module tb_smult_accum;

    logic               clk = 1'b0;
    logic               n_reset;
    logic               start;
    logic [7:0]         len_in;
    logic               op_valid;
    logic signed [7:0]  a_in, b_in;
    logic signed [15:0] product;

    logic               busy0, done0, ovf0;
    logic signed [19:0] acc0;
    logic signed [7:0]  res0;
    logic               busy7, done7, ovf7;
    logic signed [19:0] acc7;
    logic signed [7:0]  res7;

    int      cyc = 0;
    int      n_cmp = 0;
    int      n_fail = 0;
    bit      checking = 1'b0;
    int      done_cyc = -10;

    longint  pred_acc, pred_res0, pred_res7;
    bit      pred_ovf;
    longint  hold_acc = 0, hold_res0 = 0, hold_res7 = 0;
    bit      hold_ovf = 1'b0;

    int      va[64];
    int      vb[64];
    bit      vv[64];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency signed multiplier.
    always @(posedge clk) product <= 16'(a_in) * 16'(b_in);

    smult_accum #(.N(8), .ACC_W(20), .LEN_W(8), .SHIFT(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .start(start), .len(len_in),
        .op_valid(op_valid), .product(product), .busy(busy0), .done(done0),
        .acc(acc0), .result_sat(res0), .overflow(ovf0)
    );

    smult_accum #(.N(8), .ACC_W(20), .LEN_W(8), .SHIFT(7)) dut7 (
        .clk(clk), .n_reset(n_reset), .start(start), .len(len_in),
        .op_valid(op_valid), .product(product), .busy(busy7), .done(done7),
        .acc(acc7), .result_sat(res7), .overflow(ovf7)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint wrap20(input longint t);
        longint m;
        m = t & 64'hFFFFF;
        if (m > 524287) m = m - 1048576;
        return m;
    endfunction

    function automatic longint sat8(input longint v, input int sh);
        longint s;
        s = v >>> sh;
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    // Compare process: done timing every cycle, results on done and while idle.
    always @(negedge clk) begin
        bit exp_done;
        if (checking) begin
            exp_done = (cyc == done_cyc);
            chk("done", longint'(done0), longint'(exp_done));
            chk("done_s7", longint'(done7), longint'(exp_done));
            if (exp_done) begin
                chk("busy_at_done", longint'(busy0), 1);
                chk("acc_at_done", acc0, pred_acc);
                chk("res_at_done", res0, pred_res0);
                chk("ovf_at_done", longint'(ovf0), longint'(pred_ovf));
                chk("acc_s7_at_done", acc7, pred_acc);
                chk("res_s7_at_done", res7, pred_res7);
                chk("ovf_s7_at_done", longint'(ovf7), longint'(pred_ovf));
                hold_acc  = pred_acc;
                hold_res0 = pred_res0;
                hold_res7 = pred_res7;
                hold_ovf  = pred_ovf;
            end else if (!busy0) begin
                chk("busy_s7_idle", longint'(busy7), 0);
                chk("acc_hold", acc0, hold_acc);
                chk("res_hold", res0, hold_res0);
                chk("ovf_hold", longint'(ovf0), longint'(hold_ovf));
                chk("res_s7_hold", res7, hold_res7);
            end
        end
    end

    task automatic set_pair(input int i, input int a, input int b, input bit v);
        va[i] = a;
        vb[i] = b;
        vv[i] = v;
    endtask

    task automatic do_run(input int len_v, input int n, input int spur_at, input int abort_at);
        int     cnt;
        longint w, t;
        bit     ov;
        cnt = 0;
        w   = 0;
        ov  = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b1;
        len_in = 8'(len_v);
        if (len_v == 0) begin
            pred_acc  = 0;
            pred_res0 = 0;
            pred_res7 = 0;
            pred_ovf  = 1'b0;
            done_cyc  = cyc + 1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (len_v == 0) chk("zero_len_busy", longint'(busy0), 1);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                op_valid = 1'b0;
                #2;
                n_reset  = 1'b0;
                hold_acc = 0; hold_res0 = 0; hold_res7 = 0; hold_ovf = 1'b0;
                #1;
                chk("rst_busy", longint'(busy0), 0);
                chk("rst_done", longint'(done0), 0);
                chk("rst_acc", acc0, 0);
                chk("rst_res", res0, 0);
                chk("rst_ovf", longint'(ovf0), 0);
                @(posedge clk);
                #1;
                n_reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            start    = (i == spur_at);
            len_in   = (i == spur_at) ? 8'd9 : 8'(len_v);
            op_valid = vv[i];
            a_in     = 8'(va[i]);
            b_in     = 8'(vb[i]);
            if (vv[i] && cnt < len_v) begin
                t = w + longint'(va[i]) * longint'(vb[i]);
                if (t > 524287 || t < -524288) ov = 1'b1;
                w = wrap20(t);
                cnt++;
                if (cnt == len_v) begin
                    pred_acc  = w;
                    pred_res0 = sat8(w, 0);
                    pred_res7 = sat8(w, 7);
                    pred_ovf  = ov;
                    done_cyc  = cyc + 2;
                end
            end
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_reset  = 1'b0;
        start    = 1'b0;
        len_in   = '0;
        op_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_done", longint'(done0), 0);
        chk("reset_acc", acc0, 0);
        chk("reset_res", res0, 0);
        chk("reset_ovf", longint'(ovf0), 0);
        n_reset  = 1'b1;
        checking = 1'b1;

        // Basic run with a start pulse mid-run that must be ignored.
        set_pair(0, 5, 4, 1); set_pair(1, 5, -3, 1); set_pair(2, -2, -3, 1);
        do_run(3, 3, 1, -1);
        chk("basic_acc", acc0, 11);
        chk("basic_res", res0, 11);
        chk("basic_ovf", longint'(ovf0), 0);
        chk("basic_res_s7", res7, 0);

        // Bubble and an extra issue past the run length.
        set_pair(0, 3, 3, 1); set_pair(1, 0, 0, 0); set_pair(2, -4, 2, 1); set_pair(3, 7, 7, 1);
        do_run(2, 4, -1, -1);
        chk("bubble_acc", acc0, 1);
        chk("bubble_res", res0, 1);

        // Positive clamp.
        set_pair(0, 127, 127, 1); set_pair(1, 127, 127, 1);
        do_run(2, 2, -1, -1);
        chk("clamp_pos_acc", acc0, 32258);
        chk("clamp_pos_res", res0, 127);
        chk("clamp_pos_res_s7", res7, 127);

        // Negative clamp.
        set_pair(0, -128, 127, 1);
        do_run(1, 1, -1, -1);
        chk("clamp_neg_acc", acc0, -16256);
        chk("clamp_neg_res", res0, -128);
        chk("clamp_neg_res_s7", res7, -127);

        // Shift path.
        set_pair(0, 64, 64, 1);
        do_run(1, 1, -1, -1);
        chk("shift_acc", acc0, 4096);
        chk("shift_res_s0", res0, 127);
        chk("shift_res_s7", res7, 32);

        // Accumulator overflow with wrap.
        for (int i = 0; i < 33; i++) set_pair(i, 127, 127, 1);
        do_run(33, 33, -1, -1);
        chk("ovf_flag", longint'(ovf0), 1);
        chk("ovf_acc", acc0, -516319);
        chk("ovf_res", res0, -128);

        // Zero-length run also clears the sticky overflow.
        do_run(0, 0, -1, -1);
        chk("zero_acc", acc0, 0);
        chk("zero_res", res0, 0);
        chk("zero_ovf", longint'(ovf0), 0);

        // Asynchronous reset mid-run, then a short clean run.
        set_pair(0, 1, 1, 1); set_pair(1, 1, 1, 1); set_pair(2, 1, 1, 1);
        do_run(3, 3, -1, 2);
        set_pair(0, 2, 3, 1);
        do_run(1, 1, -1, -1);
        chk("post_reset_acc", acc0, 6);
        chk("post_reset_res", res0, 6);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
